iq_discriminator_mc: RTL and testbench

//  Parametrised successor of the single-pair demod front end: N_CH I/Q channel pairs, each LANES x 16-bit samples/clk.
//  On trigger, integrates NUM_PTS valid beats per channel, then classifies each integrated point against a line (perp vector + point).

---
 rtl/iq_disc_pkg.sv | 16 +
 rtl/iq_discriminator_mc_if.sv | 12 +
 rtl/iq_disc_chan.sv | 101 ++++++++++
 rtl/iq_discriminator_mc.sv | 201 ++++++++++++++++++++
 tb/tb_iq_discriminator_mc.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/iq_disc_pkg.sv
// Shared types for the multi-channel I/Q discriminator: FSM states, register map
// and the lane-sum width helper.
package iq_disc_pkg;

    typedef enum logic [2:0] {IDLE, INTEG, CLS1, CLS2, OUT} state_t;

    localparam logic [7:0] ADDR_NUM_PTS = 8'h00;
    localparam logic [7:0] ADDR_STATUS  = 8'h01;
    localparam logic [7:0] ADDR_SHIFT   = 8'h02;
    localparam logic [3:0] ADDR_CH_PAGE = 4'h1;

    function automatic int lane_sum_w(input int lanes);
        return 16 + $clog2(lanes);
    endfunction

endpackage

// File: rtl/iq_discriminator_mc_if.sv
// Memory-mapped configuration bus: word address, write strobe/data and a read
// strobe whose data returns one clock later.
interface iq_discriminator_mc_if;
    logic [7:0]  cfg_address;
    logic        cfg_wrEn;
    logic [31:0] cfg_wrData;
    logic        cfg_rdEn;
    logic [31:0] cfg_rdData;

    modport master (output cfg_address, cfg_wrEn, cfg_wrData, cfg_rdEn, input cfg_rdData);
    modport slave  (input cfg_address, cfg_wrEn, cfg_wrData, cfg_rdEn, output cfg_rdData);
endinterface

// File: rtl/iq_disc_chan.sv
// One I/Q channel: lane adder, saturating integrator with sticky overflow flag,
// and a two-stage line classifier working on the unshifted accumulators.
module iq_disc_chan
    import iq_disc_pkg::*;
#(
    parameter int LANES = 5,
    parameter int ACC_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic                    i_acc_en,
    input  logic                    i_cls1_en,
    input  logic                    i_cls2_en,
    input  logic                    i_sat_clr,
    input  logic [LANES*16-1:0]     i_data_i,
    input  logic [LANES*16-1:0]     i_data_q,
    input  logic signed [15:0]      i_i_perp,
    input  logic signed [15:0]      i_q_perp,
    input  logic [31:0]             i_i_pt,
    input  logic [31:0]             i_q_pt,
    output logic signed [ACC_W-1:0] o_acc_i,
    output logic signed [ACC_W-1:0] o_acc_q,
    output logic                    o_pos,
    output logic                    o_sat
);
    localparam int LSW = lane_sum_w(LANES);
    localparam int DW  = ACC_W + 1;
    // One bit beyond the product width so the two-term sum never wraps.
    localparam int PW  = ACC_W + 18;

    function automatic logic signed [LSW-1:0] lane_sum(input logic [LANES*16-1:0] v);
        logic signed [LSW-1:0] s;
        s = '0;
        for (int l = 0; l < LANES; l++) s = s + LSW'($signed(v[l*16 +: 16]));
        return s;
    endfunction

    // Returns {overflow, clamped sum}.
    function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] a,
                                               input logic signed [LSW-1:0] b);
        logic signed [ACC_W:0] s;
        s = DW'(a) + DW'(b);
        if (s[ACC_W] != s[ACC_W-1]) return {1'b1, s[ACC_W], {(ACC_W-1){~s[ACC_W]}}};
        return {1'b0, s[ACC_W-1:0]};
    endfunction

    logic signed [ACC_W-1:0] r_acc_i_p0, r_acc_q_p0;
    logic                    r_sat;
    logic signed [15:0]      r_i_perp, r_q_perp;
    logic signed [DW-1:0]    r_i_pt, r_q_pt;
    logic signed [DW-1:0]    r_di_p1, r_dq_p1;
    logic signed [PW-1:0]    r_p_p2;
    logic [ACC_W:0]          w_sum_i, w_sum_q;

    assign w_sum_i = sat_add(r_acc_i_p0, lane_sum(i_data_i));
    assign w_sum_q = sat_add(r_acc_q_p0, lane_sum(i_data_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc_i_p0 <= '0;
            r_acc_q_p0 <= '0;
            r_sat      <= 1'b0;
            r_i_perp   <= '0;
            r_q_perp   <= '0;
            r_i_pt     <= '0;
            r_q_pt     <= '0;
            r_di_p1    <= '0;
            r_dq_p1    <= '0;
            r_p_p2     <= '0;
        end else begin
            if (i_start) begin
                r_acc_i_p0 <= '0;
                r_acc_q_p0 <= '0;
                r_i_perp   <= i_i_perp;
                r_q_perp   <= i_q_perp;
                r_i_pt     <= DW'($signed(i_i_pt));
                r_q_pt     <= DW'($signed(i_q_pt));
            end else if (i_acc_en) begin
                r_acc_i_p0 <= w_sum_i[ACC_W-1:0];
                r_acc_q_p0 <= w_sum_q[ACC_W-1:0];
            end
            if (i_sat_clr) r_sat <= 1'b0;
            else if (i_acc_en && (w_sum_i[ACC_W] || w_sum_q[ACC_W])) r_sat <= 1'b1;
            // p1: offset from the line point
            if (i_cls1_en) begin
                r_di_p1 <= DW'(r_acc_i_p0) - r_i_pt;
                r_dq_p1 <= DW'(r_acc_q_p0) - r_q_pt;
            end
            // p2: projection onto the line normal
            if (i_cls2_en)
                r_p_p2 <= PW'(r_di_p1) * PW'(r_i_perp) + PW'(r_dq_p1) * PW'(r_q_perp);
        end
    end

    assign o_acc_i = r_acc_i_p0;
    assign o_acc_q = r_acc_q_p0;
    assign o_pos   = !r_p_p2[PW-1] && (r_p_p2 != '0);
    assign o_sat   = r_sat;

endmodule

// File: rtl/iq_discriminator_mc.sv
// Multi-channel I/Q integrate-and-classify front end with config regfile.
// Define IQ_DISC_RUNNING_AVG_EN to add the output shift register (0x02).
module iq_discriminator_mc
    import iq_disc_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int LANES = 5,
    parameter int ACC_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    iq_discriminator_mc_if.slave      cfg,
    input  logic                      trigger_in,
    input  logic [N_CH*LANES*16-1:0]  data_i_in,
    input  logic [N_CH*LANES*16-1:0]  data_q_in,
    input  logic                      data_valid,
    output logic                      res_valid,
    output logic [N_CH-1:0]           res_state,
    output logic [N_CH*ACC_W-1:0]     res_i,
    output logic [N_CH*ACC_W-1:0]     res_q,
    output logic                      trigger_out
);
    localparam int CW = LANES * 16;

    logic [15:0]        r_num_pts, r_num_snap, r_beat_cnt, r_missed;
    logic signed [15:0] r_i_perp [N_CH];
    logic signed [15:0] r_q_perp [N_CH];
    logic [31:0]        r_i_pt   [N_CH];
    logic [31:0]        r_q_pt   [N_CH];
    logic [31:0]        r_rd_data;
    logic               r_trig_d;
    state_t             r_state, w_next;
`ifdef IQ_DISC_RUNNING_AVG_EN
    logic [4:0]         r_shift, r_shift_snap;
`endif

    logic w_rise, w_start, w_acc_en, w_last, w_cls1_en, w_cls2_en, w_out_en;
    logic w_stat_clr, w_ch_hit;
    logic [31:0] w_rd_val;
    logic [N_CH-1:0] w_pos, w_sat;
    logic signed [ACC_W-1:0] w_acc_i [N_CH];
    logic signed [ACC_W-1:0] w_acc_q [N_CH];

    assign w_rise     = trigger_in && !r_trig_d;
    assign w_stat_clr = cfg.cfg_wrEn && (cfg.cfg_address == ADDR_STATUS);
    assign w_ch_hit   = (cfg.cfg_address[7:4] == ADDR_CH_PAGE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_num_pts <= '0;
`ifdef IQ_DISC_RUNNING_AVG_EN
            r_shift   <= '0;
`endif
            for (int c = 0; c < N_CH; c++) begin
                r_i_perp[c] <= '0;
                r_q_perp[c] <= '0;
                r_i_pt[c]   <= '0;
                r_q_pt[c]   <= '0;
            end
        end else if (cfg.cfg_wrEn) begin
            if (cfg.cfg_address == ADDR_NUM_PTS) r_num_pts <= cfg.cfg_wrData[15:0];
`ifdef IQ_DISC_RUNNING_AVG_EN
            if (cfg.cfg_address == ADDR_SHIFT) r_shift <= cfg.cfg_wrData[4:0];
`endif
            for (int c = 0; c < N_CH; c++) begin
                if (w_ch_hit && cfg.cfg_address[3:2] == 2'(c)) begin
                    case (cfg.cfg_address[1:0])
                        2'd0:    r_i_perp[c] <= cfg.cfg_wrData[15:0];
                        2'd1:    r_q_perp[c] <= cfg.cfg_wrData[15:0];
                        2'd2:    r_i_pt[c]   <= cfg.cfg_wrData;
                        default: r_q_pt[c]   <= cfg.cfg_wrData;
                    endcase
                end
            end
        end
    end

    // Reads see the pre-write register contents, so a same-cycle write is invisible.
    always_comb begin
        w_rd_val = '0;
        if (cfg.cfg_address == ADDR_NUM_PTS) w_rd_val = {16'h0, r_num_pts};
        if (cfg.cfg_address == ADDR_STATUS)  w_rd_val = {r_missed, 16'(w_sat)};
`ifdef IQ_DISC_RUNNING_AVG_EN
        if (cfg.cfg_address == ADDR_SHIFT)   w_rd_val = {27'h0, r_shift};
`endif
        for (int c = 0; c < N_CH; c++) begin
            if (w_ch_hit && cfg.cfg_address[3:2] == 2'(c)) begin
                case (cfg.cfg_address[1:0])
                    2'd0:    w_rd_val = {16'h0, r_i_perp[c]};
                    2'd1:    w_rd_val = {16'h0, r_q_perp[c]};
                    2'd2:    w_rd_val = r_i_pt[c];
                    default: w_rd_val = r_q_pt[c];
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rd_data <= '0;
        else     r_rd_data <= cfg.cfg_rdEn ? w_rd_val : '0;
    end
    assign cfg.cfg_rdData = r_rd_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next = INTEG;
            INTEG:   if (w_last)  w_next = CLS1;
            CLS1:    w_next = CLS2;
            CLS2:    w_next = OUT;
            OUT:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_start   = (r_state == IDLE) && w_rise && (r_num_pts != 16'd0);
        w_acc_en  = (r_state == INTEG) && data_valid;
        w_last    = w_acc_en && (r_beat_cnt == r_num_snap - 16'd1);
        w_cls1_en = (r_state == CLS1);
        w_cls2_en = (r_state == CLS2);
        w_out_en  = (r_state == OUT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_trig_d     <= 1'b0;
            r_num_snap   <= '0;
            r_beat_cnt   <= '0;
            r_missed     <= '0;
`ifdef IQ_DISC_RUNNING_AVG_EN
            r_shift_snap <= '0;
`endif
        end else begin
            r_trig_d <= trigger_in;
            if (w_start) begin
                r_num_snap   <= r_num_pts;
`ifdef IQ_DISC_RUNNING_AVG_EN
                r_shift_snap <= r_shift;
`endif
            end
            if (w_start)       r_beat_cnt <= '0;
            else if (w_acc_en) r_beat_cnt <= r_beat_cnt + 16'd1;
            if (w_stat_clr) r_missed <= '0;
            else if (w_rise && r_state != IDLE && r_missed != 16'hFFFF) r_missed <= r_missed + 16'd1;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        iq_disc_chan #(.LANES(LANES), .ACC_W(ACC_W)) u_chan (
            .clk       (clk),
            .rst       (rst),
            .i_start   (w_start),
            .i_acc_en  (w_acc_en),
            .i_cls1_en (w_cls1_en),
            .i_cls2_en (w_cls2_en),
            .i_sat_clr (w_start || w_stat_clr),
            .i_data_i  (data_i_in[c*CW +: CW]),
            .i_data_q  (data_q_in[c*CW +: CW]),
            .i_i_perp  (r_i_perp[c]),
            .i_q_perp  (r_q_perp[c]),
            .i_i_pt    (r_i_pt[c]),
            .i_q_pt    (r_q_pt[c]),
            .o_acc_i   (w_acc_i[c]),
            .o_acc_q   (w_acc_q[c]),
            .o_pos     (w_pos[c]),
            .o_sat     (w_sat[c])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_state <= '0;
            res_i     <= '0;
            res_q     <= '0;
        end else begin
            res_valid <= w_out_en;
            if (w_out_en) begin
                res_state <= w_pos;
                for (int c = 0; c < N_CH; c++) begin
`ifdef IQ_DISC_RUNNING_AVG_EN
                    res_i[c*ACC_W +: ACC_W] <= w_acc_i[c] >>> r_shift_snap;
                    res_q[c*ACC_W +: ACC_W] <= w_acc_q[c] >>> r_shift_snap;
`else
                    res_i[c*ACC_W +: ACC_W] <= w_acc_i[c];
                    res_q[c*ACC_W +: ACC_W] <= w_acc_q[c];
`endif
                end
            end
        end
    end

    assign trigger_out = res_valid;

endmodule

// File: tb/tb_iq_discriminator_mc.sv
// Directed bench for iq_discriminator_mc with two channels and a 20-bit
// accumulator; expected values are worked out by hand for each step.
module tb_iq_discriminator_mc;
    localparam int N_CH  = 2;
    localparam int LANES = 5;
    localparam int ACC_W = 20;
    localparam int DWID  = N_CH * LANES * 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic trigger_in = 1'b0;
    logic data_valid = 1'b0;
    logic [DWID-1:0] data_i_in = '0;
    logic [DWID-1:0] data_q_in = '0;
    logic res_valid, trigger_out;
    logic [N_CH-1:0] res_state;
    logic [N_CH*ACC_W-1:0] res_i, res_q;

    int total = 0;
    int bad = 0;
    int cnt;
    bit seen;
    logic [31:0] rd;

    iq_discriminator_mc_if cfg_bus();

    iq_discriminator_mc #(.N_CH(N_CH), .LANES(LANES), .ACC_W(ACC_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg         (cfg_bus),
        .trigger_in  (trigger_in),
        .data_i_in   (data_i_in),
        .data_q_in   (data_q_in),
        .data_valid  (data_valid),
        .res_valid   (res_valid),
        .res_state   (res_state),
        .res_i       (res_i),
        .res_q       (res_q),
        .trigger_out (trigger_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] a20(input int v);
        return v[19:0];
    endfunction

    task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        cfg_bus.cfg_address = a;
        cfg_bus.cfg_wrData  = d;
        cfg_bus.cfg_wrEn    = 1'b1;
        @(negedge clk);
        cfg_bus.cfg_wrEn    = 1'b0;
    endtask

    task automatic cfg_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        cfg_bus.cfg_address = a;
        cfg_bus.cfg_rdEn    = 1'b1;
        @(negedge clk);
        cfg_bus.cfg_rdEn    = 1'b0;
        d = cfg_bus.cfg_rdData;
    endtask

    task automatic set_ch(input int ch, input int iv, input int qv);
        for (int l = 0; l < LANES; l++) begin
            data_i_in[(ch*LANES+l)*16 +: 16] = iv[15:0];
            data_q_in[(ch*LANES+l)*16 +: 16] = qv[15:0];
        end
    endtask

    task automatic trig();
        @(negedge clk);
        trigger_in = 1'b1;
        @(negedge clk);
        trigger_in = 1'b0;
    endtask

    task automatic wait_res(input int maxc, output int n, output bit s);
        n = 0;
        s = 1'b0;
        while (n < maxc && !s) begin
            @(negedge clk);
            n++;
            if (res_valid) s = 1'b1;
        end
    endtask

    initial begin
        cfg_bus.cfg_address = '0;
        cfg_bus.cfg_wrEn    = 1'b0;
        cfg_bus.cfg_wrData  = '0;
        cfg_bus.cfg_rdEn    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", res_valid, 1'b0);
        chk("rst_trig_out", trigger_out, 1'b0);
        chk("rst_state", res_state, 2'b00);
        chk("rst_res_i", res_i, 40'h0);
        chk("rst_res_q", res_q, 40'h0);
        rst = 1'b0;
        cfg_read(8'h01, rd);
        chk("rst_status", rd, 32'h0);
        cfg_read(8'h00, rd);
        chk("rst_num_pts", rd, 32'h0);

        // Basic run: both channels +100 on every I lane, 4 beats.
        cfg_write(8'h00, 32'd4);
        cfg_write(8'h10, 32'd1);
        cfg_write(8'h14, 32'd1);
        cfg_read(8'h00, rd);
        chk("num_pts_rb", rd, 32'd4);
        cfg_read(8'h14, rd);
        chk("iperp1_rb", rd, 32'd1);
        set_ch(0, 100, 0);
        set_ch(1, 100, 0);
        data_valid = 1'b1;
        trig();
        wait_res(30, cnt, seen);
        chk("basic_seen", seen, 1'b1);
        chk("basic_latency", cnt, 7);
        chk("basic_ri0", res_i[19:0], a20(2000));
        chk("basic_ri1", res_i[39:20], a20(2000));
        chk("basic_rq", res_q, 40'h0);
        chk("basic_state", res_state, 2'b11);
        chk("basic_trig_out", trigger_out, 1'b1);
        @(negedge clk);
        chk("basic_pulse", res_valid, 1'b0);
        chk("basic_hold", res_i[19:0], a20(2000));

        // Channel 1 negative.
        set_ch(1, -100, 0);
        trig();
        wait_res(30, cnt, seen);
        chk("neg_state", res_state, 2'b01);
        chk("neg_ri1", res_i[39:20], a20(-2000));
        chk("neg_ri0", res_i[19:0], a20(2000));

        // Line point and Q normal: ch0 p=-500, ch1 p=3000-2000=1000.
        cfg_write(8'h12, 32'd2500);
        cfg_write(8'h16, -5000);
        cfg_write(8'h15, 32'd1);
        set_ch(1, -100, -100);
        trig();
        wait_res(30, cnt, seen);
        chk("pt_state", res_state, 2'b10);
        chk("pt_rq1", res_q[39:20], a20(-2000));
        cfg_write(8'h12, 32'd0);
        cfg_write(8'h16, 32'd0);
        cfg_write(8'h15, 32'd0);

        // data_valid every other cycle: beats on cycles 1,3,5,7 of 8.
        data_valid = 1'b0;
        set_ch(0, 100, 7);
        set_ch(1, 50, 7);
        trig();
        for (int i = 0; i < 8; i++) begin
            data_valid = (i % 2 == 0);
            @(negedge clk);
        end
        data_valid = 1'b0;
        chk("gap_not_early", res_valid, 1'b0);
        wait_res(20, cnt, seen);
        chk("gap_latency", cnt, 2);
        chk("gap_ri0", res_i[19:0], a20(2000));
        chk("gap_ri1", res_i[39:20], a20(1000));
        chk("gap_rq0", res_q[19:0], a20(140));
        chk("gap_rq1", res_q[39:20], a20(140));
        chk("gap_state", res_state, 2'b11);

        // Positive saturation: 10 x 163835 exceeds 2^19-1.
        cfg_write(8'h00, 32'd10);
        set_ch(0, 32767, 0);
        set_ch(1, 32767, 0);
        data_valid = 1'b1;
        trig();
        wait_res(40, cnt, seen);
        chk("sat_latency", cnt, 13);
        chk("sat_ri0", res_i[19:0], a20(524287));
        chk("sat_ri1", res_i[39:20], a20(524287));
        cfg_read(8'h01, rd);
        chk("sat_status", rd, 32'h0000_0003);
        cfg_write(8'h01, 32'h0);
        cfg_read(8'h01, rd);
        chk("sat_cleared", rd, 32'h0);

        // Two extra trigger edges while integrating.
        cfg_write(8'h00, 32'd4);
        set_ch(0, 100, 0);
        set_ch(1, 100, 0);
        data_valid = 1'b0;
        trig();
        trig();
        trig();
        data_valid = 1'b1;
        wait_res(30, cnt, seen);
        chk("miss_seen", seen, 1'b1);
        chk("miss_ri0", res_i[19:0], a20(2000));
        cfg_read(8'h01, rd);
        chk("miss_status", rd, 32'h0002_0000);
        cfg_write(8'h00, 32'd0);
        trig();
        wait_res(20, cnt, seen);
        chk("zero_pts_no_res", seen, 1'b0);
        cfg_read(8'h01, rd);
        chk("zero_pts_missed", rd, 32'h0002_0000);

        // Reset in the middle of integration.
        cfg_write(8'h00, 32'd4);
        set_ch(0, 300, 0);
        set_ch(1, 300, 0);
        data_valid = 1'b0;
        trig();
        data_valid = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_valid", res_valid, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("midrst_no_res", res_valid, 1'b0);
        chk("midrst_res_i", res_i, 40'h0);
        cfg_read(8'h01, rd);
        chk("midrst_status", rd, 32'h0);
        cfg_read(8'h00, rd);
        chk("midrst_num_pts", rd, 32'h0);
        cfg_write(8'h00, 32'd4);
        cfg_write(8'h10, 32'd1);
        cfg_write(8'h14, 32'd1);
        set_ch(0, 100, 0);
        set_ch(1, 100, 0);
        trig();
        wait_res(30, cnt, seen);
        chk("rerun_latency", cnt, 7);
        chk("rerun_ri0", res_i[19:0], a20(2000));
        chk("rerun_ri1", res_i[39:20], a20(2000));
        chk("rerun_state", res_state, 2'b11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
